// File: rtl/seq_signed_divider_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg : shared types and helpers for the sequential signed divider.
//   state_t        controller states
//   DIV_WIDTH      default operand width
//   cnt_bits()     iteration-counter width for a given operand width
//   CNT_W          counter width at the default operand width
//   negate()       two's-complement negation of a default-width word
//   sat_abs()      unsigned magnitude of a default-width signed word
// ---------------------------------------------------------------------------
package div_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      FIXUP  = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int DIV_WIDTH = 8;

   function automatic int cnt_bits(input int w);
      return (w > 2) ? $clog2(w) : 1;
   endfunction

   localparam int CNT_W = cnt_bits(DIV_WIDTH);

   typedef logic [DIV_WIDTH-1:0] word_t;

   function automatic word_t negate(input word_t v);
      return ~v + word_t'(1);
   endfunction

   // The magnitude is read as unsigned, so the most-negative value maps to
   // 2^(W-1) exactly; nothing has to be clipped.
   function automatic word_t sat_abs(input word_t v);
      return v[DIV_WIDTH-1] ? negate(v) : v;
   endfunction

endpackage

// File: rtl/seq_signed_divider_if.sv
// ---------------------------------------------------------------------------
// seq_signed_divider_if : operand and result handshakes of the divider.
//   in_valid/in_ready      operand handshake (dividend, divisor)
//   out_valid/out_ready    result handshake (quotient, remainder, flags)
//   master : operand producer / result consumer side
//   slave  : divider side
// ---------------------------------------------------------------------------
interface seq_signed_divider_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;
   logic             overflow;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
   );
endinterface

// File: rtl/seq_signed_divider_adder.sv
// ---------------------------------------------------------------------------
// seq_signed_divider_adder : combinational W-bit adder with carry-in.
//   a_i, b_i   addends
//   cin_i      carry in
//   sum_o      a_i + b_i + cin_i, modulo 2^W
// Subtraction a - b is done by feeding b_i = ~b and cin_i = 1.
// ---------------------------------------------------------------------------
module seq_signed_divider_adder #(
   parameter int W = 9
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         cin_i,
   output logic [W-1:0] sum_o
);
   assign sum_o = a_i + b_i + {{(W-1){1'b0}}, cin_i};
endmodule

// File: rtl/seq_signed_divider.sv
// ---------------------------------------------------------------------------
// seq_signed_divider : multi-cycle signed divider, restoring shift/subtract,
// one quotient bit per clock. Quotient truncates toward zero, remainder takes
// the sign of the dividend.
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   bus      seq_signed_divider_if.slave (operand and result handshakes)
// Latency: accept edge = 0, out_valid after edge WIDTH+1; divide-by-zero
// results appear after the accept edge itself.
// ---------------------------------------------------------------------------
module seq_signed_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   seq_signed_divider_if.slave  bus
);
   localparam int CNT_BITS = cnt_bits(WIDTH);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t              state_q;
   logic [CNT_BITS-1:0] cnt_q;
   logic [WIDTH-1:0]    rem_q;       // partial remainder (magnitude)
   logic [WIDTH-1:0]    dvd_q;       // dividend magnitude, shifts into quotient
   logic [WIDTH-1:0]    dvs_q;       // divisor magnitude
   logic                sign_q_q;    // quotient must be negated
   logic                sign_r_q;    // remainder must be negated
   logic                ovf_q;       // most-negative / -1 seen at accept
   logic                in_ready_q;
   logic                out_valid_q;
   logic [WIDTH-1:0]    quotient_q;
   logic [WIDTH-1:0]    remainder_q;
   logic                div_by_zero_q;
   logic                overflow_q;

   // Trial subtraction {rem, dvd MSB} - |divisor| at WIDTH+1 bits. The
   // partial remainder stays below |divisor| <= 2^(WIDTH-1), so the shifted
   // value fits and the top sum bit is the sign of the trial.
   logic [WIDTH:0] trial_a;
   logic [WIDTH:0] trial_b;
   logic [WIDTH:0] trial_sum;
   logic           trial_ge;

   assign trial_a  = {rem_q, dvd_q[WIDTH-1]};
   assign trial_b  = ~{1'b0, dvs_q};
   assign trial_ge = ~trial_sum[WIDTH];

   seq_signed_divider_adder #(
      .W (WIDTH + 1)
   ) u_adder (
      .a_i   (trial_a),
      .b_i   (trial_b),
      .cin_i (1'b1),
      .sum_o (trial_sum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         rem_q         <= '0;
         dvd_q         <= '0;
         dvs_q         <= '0;
         sign_q_q      <= 1'b0;
         sign_r_q      <= 1'b0;
         ovf_q         <= 1'b0;
         in_ready_q    <= 1'b1;
         out_valid_q   <= 1'b0;
         quotient_q    <= '0;
         remainder_q   <= '0;
         div_by_zero_q <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  in_ready_q <= 1'b0;
                  dvd_q      <= bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
                  dvs_q      <= bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
                  sign_q_q   <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                  sign_r_q   <= bus.dividend[WIDTH-1];
                  ovf_q      <= (bus.dividend == MOST_NEG) && (bus.divisor == '1);
                  rem_q      <= '0;
                  cnt_q      <= CNT_BITS'(WIDTH - 1);
                  if (bus.divisor == '0) begin
                     // No iterations needed: publish the fixed result now.
                     quotient_q    <= '1;
                     remainder_q   <= bus.dividend;
                     div_by_zero_q <= 1'b1;
                     overflow_q    <= 1'b0;
                     out_valid_q   <= 1'b1;
                     state_q       <= DONE;
                  end else begin
                     state_q <= DIVIDE;
                  end
               end
            end

            DIVIDE: begin
               // Restore simply means keeping the shifted value unchanged.
               rem_q <= trial_ge ? trial_sum[WIDTH-1:0] : trial_a[WIDTH-1:0];
               dvd_q <= {dvd_q[WIDTH-2:0], trial_ge};
               if (cnt_q == '0) begin
                  state_q <= FIXUP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end

            FIXUP: begin
               // For most-negative / -1 the magnitude 2^(WIDTH-1) with no
               // negation already reads back as the most-negative value.
               quotient_q    <= sign_q_q ? -dvd_q : dvd_q;
               remainder_q   <= sign_r_q ? -rem_q : rem_q;
               div_by_zero_q <= 1'b0;
               overflow_q    <= ovf_q;
               out_valid_q   <= 1'b1;
               state_q       <= DONE;
            end

            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.div_by_zero = div_by_zero_q;
   assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
module tb_seq_signed_divider;
   localparam int WIDTH = 8;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   seq_signed_divider_if #(.WIDTH(WIDTH)) dif ();

   seq_signed_divider #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Apply one division; returns the result and the edge index (accept edge
   // is 0) after which out_valid was first seen. hold = cycles of withheld
   // out_ready; junk = present other operands while the divider is busy.
   task automatic do_div(input logic [7:0] a, input logic [7:0] b, input int hold,
                         input bit junk,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic dz, output logic ov, output int lat);
      @(negedge clk);
      dif.in_valid = 1'b1;
      dif.dividend = a;
      dif.divisor  = b;
      @(posedge clk);
      #1;
      if (junk) begin
         dif.dividend = ~a;
         dif.divisor  = 8'd3;
      end else begin
         dif.in_valid = 1'b0;
      end
      lat = 0;
      while (!dif.out_valid && lat < 40) begin
         chk("busy_in_ready", {31'd0, dif.in_ready}, 32'd0);
         @(posedge clk);
         #1;
         lat++;
      end
      dif.in_valid = 1'b0;
      q  = dif.quotient;
      r  = dif.remainder;
      dz = dif.div_by_zero;
      ov = dif.overflow;
      chk("out_valid_seen", {31'd0, dif.out_valid}, 32'd1);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         chk("hold_valid", {31'd0, dif.out_valid}, 32'd1);
         chk("hold_in_ready", {31'd0, dif.in_ready}, 32'd0);
         chk("hold_q", {24'd0, dif.quotient}, {24'd0, q});
         chk("hold_r", {24'd0, dif.remainder}, {24'd0, r});
      end
      @(negedge clk);
      dif.out_ready = 1'b1;
      @(posedge clk);
      #1;
      dif.out_ready = 1'b0;
      chk("consumed_valid", {31'd0, dif.out_valid}, 32'd0);
      chk("consumed_in_ready", {31'd0, dif.in_ready}, 32'd1);
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
      logic       ov;
      int         lat;
   } vec_t;

   vec_t vecs[12];

   initial begin
      logic [7:0] q, r;
      logic       dz, ov;
      int         lat;
      n_vec = 0;
      n_err = 0;

      //            a      b      q      r      dz    ov    lat
      vecs[0]  = '{8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 1'b0, 9};
      vecs[1]  = '{8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0, 1'b0, 9};   // -100 / 7
      vecs[2]  = '{8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0, 9};   // 100 / -7
      vecs[3]  = '{8'h9C,  8'hF9,  8'h0E, 8'hFE, 1'b0, 1'b0, 9};   // -100 / -7
      vecs[4]  = '{8'd37,  8'd0,   8'hFF, 8'h25, 1'b1, 1'b0, 0};   // 37 / 0
      vecs[5]  = '{8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 1'b1, 9};   // -128 / -1
      vecs[6]  = '{8'h80,  8'd1,   8'h80, 8'h00, 1'b0, 1'b0, 9};   // -128 / 1
      vecs[7]  = '{8'h80,  8'd0,   8'hFF, 8'h80, 1'b1, 1'b0, 0};   // -128 / 0
      vecs[8]  = '{8'd127, 8'h80,  8'h00, 8'h7F, 1'b0, 1'b0, 9};   // 127 / -128
      vecs[9]  = '{8'h80,  8'd127, 8'hFF, 8'hFF, 1'b0, 1'b0, 9};   // -128 / 127
      vecs[10] = '{8'd6,   8'd7,   8'h00, 8'h06, 1'b0, 1'b0, 9};   // 6 / 7
      vecs[11] = '{8'hF9,  8'd7,   8'hFF, 8'h00, 1'b0, 1'b0, 9};   // -7 / 7

      dif.in_valid  = 1'b0;
      dif.out_ready = 1'b0;
      dif.dividend  = '0;
      dif.divisor   = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, dif.in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, dif.out_valid}, 32'd0);
      chk("rst_q", {24'd0, dif.quotient}, 32'd0);
      chk("rst_r", {24'd0, dif.remainder}, 32'd0);
      chk("rst_flags", {30'd0, dif.div_by_zero, dif.overflow}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         do_div(vecs[i].a, vecs[i].b, 0, 1'b0, q, r, dz, ov, lat);
         $display("vec %0d: %0d / %0d -> q=0x%02h r=0x%02h dz=%0b ov=%0b lat=%0d",
                  i, $signed(vecs[i].a), $signed(vecs[i].b), q, r, dz, ov, lat);
         chk($sformatf("v%0d_q", i), {24'd0, q}, {24'd0, vecs[i].q});
         chk($sformatf("v%0d_r", i), {24'd0, r}, {24'd0, vecs[i].r});
         chk($sformatf("v%0d_dz", i), {31'd0, dz}, {31'd0, vecs[i].dz});
         chk($sformatf("v%0d_ov", i), {31'd0, ov}, {31'd0, vecs[i].ov});
         chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      end

      // Backpressure: result held 5 cycles, operands for another job waiting.
      do_div(8'd127, 8'd3, 5, 1'b1, q, r, dz, ov, lat);
      $display("bp: 127 / 3 -> q=0x%02h r=0x%02h lat=%0d", q, r, lat);
      chk("bp_q", {24'd0, q}, 32'd42);
      chk("bp_r", {24'd0, r}, 32'd1);
      chk("bp_lat", lat, 9);

      // Reset in the middle of DIVIDE.
      @(negedge clk);
      dif.in_valid = 1'b1;
      dif.dividend = 8'd100;
      dif.divisor  = 8'd7;
      @(posedge clk);
      #1;
      dif.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      $display("mid-divide reset: in_ready=%0b out_valid=%0b q=0x%02h r=0x%02h",
               dif.in_ready, dif.out_valid, dif.quotient, dif.remainder);
      chk("mrst_in_ready", {31'd0, dif.in_ready}, 32'd1);
      chk("mrst_out_valid", {31'd0, dif.out_valid}, 32'd0);
      chk("mrst_q", {24'd0, dif.quotient}, 32'd0);
      chk("mrst_r", {24'd0, dif.remainder}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("mrst_no_result", {31'd0, dif.out_valid}, 32'd0);
      end
      do_div(8'd9, 8'd2, 0, 1'b0, q, r, dz, ov, lat);
      $display("after reset: 9 / 2 -> q=0x%02h r=0x%02h lat=%0d", q, r, lat);
      chk("ar_q", {24'd0, q}, 32'd4);
      chk("ar_r", {24'd0, r}, 32'd1);
      chk("ar_lat", lat, 9);

      // Random signed pairs against a truncating integer reference.
      for (int k = 0; k < 300; k++) begin
         logic [7:0] ra, rb;
         int sa, sb, eq, er;
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(1, 255));
         sa = int'($signed(ra));
         sb = int'($signed(rb));
         eq = sa / sb;
         er = sa % sb;
         do_div(ra, rb, k % 3, k[0], q, r, dz, ov, lat);
         $display("rnd %0d: %0d / %0d -> q=0x%02h r=0x%02h ov=%0b", k, sa, sb, q, r, ov);
         chk("rnd_q", {24'd0, q}, {24'd0, eq[7:0]});
         chk("rnd_r", {24'd0, r}, {24'd0, er[7:0]});
         chk("rnd_dz", {31'd0, dz}, 32'd0);
         chk("rnd_ov", {31'd0, ov}, {31'd0, (sa == -128) && (sb == -1)});
         chk("rnd_lat", lat, 9);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
